// File: rtl/ahblite_uart.sv
// ahblite_uart: AHB-Lite UART slave with 8N1 transmitter and TX FIFO, single-byte receiver, baud divisor and level IRQ
module ahblite_uart #(
    parameter int BAUD_DIV = 434,
    parameter int TX_DEPTH = 8
) (
    input  logic        clk,
    input  logic        RSTn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP,
    input  logic        RXD,
    output logic        TXD,
    output logic        IRQ_UART
);
    localparam int AW = $clog2(TX_DEPTH);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic        acc, wr_q, rd_q, push, data_rd, st_wr, full, empty, tx_busy;
    logic [1:0]  addr_q, ctrl;
    logic [15:0] baud;
    logic [7:0]  rx_data;
    logic        rx_valid, overrun, ferr, irq_q;
    logic [7:0]  mem [TX_DEPTH];
    logic [AW:0] wp, rp;
    logic        unused_ok;

    state_t      tx_st, tx_st_n;
    logic [15:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
    logic [7:0]  tx_sh, tx_sh_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic        tx_end, tx_pop;

    state_t      rx_st, rx_st_n;
    logic [15:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
    logic [7:0]  rx_sh, rx_sh_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic        rx_end, rx_ok, rx_fe, rs1, rs2;

    assign acc       = HSEL & HTRANS[1] & HREADY;
    assign push      = wr_q && addr_q == 2'd0 && !full;
    assign data_rd   = rd_q && addr_q == 2'd0;
    assign st_wr     = wr_q && addr_q == 2'd1;
    assign full      = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign empty     = wp == rp;
    assign tx_busy   = tx_st != IDLE;
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign IRQ_UART  = irq_q;
    assign unused_ok = ^{HSIZE, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:16]};
    assign HRDATA    = addr_q == 2'd0 ? {24'd0, rx_data} :
                       addr_q == 2'd1 ? {26'd0, ferr, tx_busy, overrun, rx_valid, empty, full} :
                       addr_q == 2'd2 ? {30'd0, ctrl} : {16'd0, baud};

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            addr_q   <= 2'd0;
            ctrl     <= 2'd0;
            baud     <= 16'(BAUD_DIV);
            wp       <= '0;
            rp       <= '0;
            rx_data  <= 8'd0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
            ferr     <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            wr_q     <= acc & HWRITE;
            rd_q     <= acc & ~HWRITE;
            addr_q   <= acc ? HADDR[3:2] : addr_q;
            ctrl     <= wr_q && addr_q == 2'd2 ? HWDATA[1:0] : ctrl;
            baud     <= wr_q && addr_q == 2'd3 ? (HWDATA[15:0] < 16'd4 ? 16'd4 : HWDATA[15:0]) : baud;
            wp       <= wp + (AW+1)'(push);
            rp       <= rp + (AW+1)'(tx_pop);
            rx_data  <= rx_ok ? rx_sh : rx_data;
            // a completing frame beats a same-cycle DATA read, so no overrun in that case
            rx_valid <= rx_ok | (rx_valid & ~data_rd);
            overrun  <= (rx_ok & rx_valid & ~data_rd) | (overrun & ~(st_wr & HWDATA[3]));
            ferr     <= rx_fe | (ferr & ~(st_wr & HWDATA[5]));
            irq_q    <= (rx_valid & ctrl[0]) | (empty & ~tx_busy & ctrl[1]);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp[AW-1:0]] <= HWDATA[7:0];
    end

    assign tx_end = tx_cnt == tx_div - 16'd1;
    assign tx_pop = !empty && (tx_st == IDLE || (tx_st == STOP && tx_end));
    assign TXD    = tx_st == START ? 1'b0 : tx_st == DATA ? tx_sh[0] : 1'b1;

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            tx_st  <= IDLE;
            tx_cnt <= 16'd0;
            tx_div <= 16'd4;
            tx_sh  <= 8'd0;
            tx_bit <= 3'd0;
        end else begin
            tx_st  <= tx_st_n;
            tx_cnt <= tx_cnt_n;
            tx_div <= tx_div_n;
            tx_sh  <= tx_sh_n;
            tx_bit <= tx_bit_n;
        end
    end

    always_comb begin
        tx_st_n  = tx_st;
        tx_cnt_n = tx_cnt + 16'd1;
        tx_div_n = tx_div;
        tx_sh_n  = tx_sh;
        tx_bit_n = tx_bit;
        case (tx_st)
            IDLE:  tx_cnt_n = 16'd0;
            START: if (tx_end) begin
                tx_st_n  = DATA;
                tx_cnt_n = 16'd0;
            end
            DATA:  if (tx_end) begin
                tx_cnt_n = 16'd0;
                tx_sh_n  = tx_sh >> 1;
                tx_bit_n = tx_bit + 3'd1;
                tx_st_n  = tx_bit == 3'd7 ? STOP : DATA;
            end
            STOP:  if (tx_end) tx_st_n = IDLE;
        endcase
        // popping overrides the above: starts a frame from IDLE or straight after a stop bit
        if (tx_pop) begin
            tx_st_n  = START;
            tx_cnt_n = 16'd0;
            tx_div_n = baud;
            tx_sh_n  = mem[rp[AW-1:0]];
            tx_bit_n = 3'd0;
        end
    end

    assign rx_end = rx_cnt == (rx_st == START ? (rx_div >> 1) - 16'd1 : rx_div - 16'd1);

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            rs1    <= 1'b1;
            rs2    <= 1'b1;
            rx_st  <= IDLE;
            rx_cnt <= 16'd0;
            rx_div <= 16'd4;
            rx_sh  <= 8'd0;
            rx_bit <= 3'd0;
        end else begin
            rs1    <= RXD;
            rs2    <= rs1;
            rx_st  <= rx_st_n;
            rx_cnt <= rx_cnt_n;
            rx_div <= rx_div_n;
            rx_sh  <= rx_sh_n;
            rx_bit <= rx_bit_n;
        end
    end

    always_comb begin
        rx_st_n  = rx_st;
        rx_cnt_n = rx_cnt + 16'd1;
        rx_div_n = rx_div;
        rx_sh_n  = rx_sh;
        rx_bit_n = rx_bit;
        rx_ok    = 1'b0;
        rx_fe    = 1'b0;
        case (rx_st)
            IDLE:  begin
                rx_cnt_n = 16'd0;
                rx_st_n  = rs2 ? IDLE : START;
                rx_div_n = rs2 ? rx_div : baud;
            end
            START: if (rx_end) begin
                rx_cnt_n = 16'd0;
                rx_bit_n = 3'd0;
                rx_st_n  = rs2 ? IDLE : DATA;
            end
            DATA:  if (rx_end) begin
                rx_cnt_n = 16'd0;
                rx_sh_n  = {rs2, rx_sh[7:1]};
                rx_bit_n = rx_bit + 3'd1;
                rx_st_n  = rx_bit == 3'd7 ? STOP : DATA;
            end
            STOP:  if (rx_end) begin
                rx_st_n = IDLE;
                rx_ok   = rs2;
                rx_fe   = !rs2;
            end
        endcase
    end
endmodule

// File: tb/tb_ahblite_uart.sv
// tb_ahblite_uart: scoreboarded random bench for ahblite_uart against a queue/bit-level reference model
module tb_ahblite_uart;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        RSTn, HSEL, HWRITE, HREADY, RXD;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HREADYOUT, HRESP, TXD, IRQ_UART;
    logic [31:0] HRDATA;

    ahblite_uart #(.BAUD_DIV(8), .TX_DEPTH(DEPTH)) dut (
        .clk(clk), .RSTn(RSTn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE),
        .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA),
        .HRESP(HRESP), .RXD(RXD), .TXD(TXD), .IRQ_UART(IRQ_UART)
    );

    initial forever #5 clk = ~clk;

    typedef struct {string nm; int sel; logic [31:0] v;} chk_t;
    chk_t       rd_q[$], pin_q[$];
    logic [7:0] tx_q[$];
    int         n_cmp = 0, n_bad = 0;
    int         m_baud = 8;
    logic       m_rxv = 0, m_ovr = 0, m_ferr = 0;
    logic [7:0] m_rx_data = 0;
    logic       rd_dp;

    // serial monitor state: one frame is checked cycle-by-cycle against its queued byte
    int         tx_cyc = -1, tx_div = 8;
    logic [7:0] tx_exp, tx_got;
    logic       tx_ok, tx_unexp;

    always @(posedge clk or negedge RSTn) begin
        if (!RSTn) rd_dp <= 1'b0;
        else rd_dp <= HSEL & HTRANS[1] & HREADY & ~HWRITE;
    end

    always @(negedge clk) begin
        chk_t e;
        logic [31:0] act;
        int b;
        logic eb;
        if (!RSTn) tx_cyc = -1;
        else begin
            if (tx_cyc < 0 && TXD === 1'b0) begin
                tx_unexp = tx_q.size() == 0;
                tx_exp   = tx_unexp ? 8'h00 : tx_q.pop_front();
                tx_div   = m_baud;
                tx_cyc   = 0;
                tx_ok    = 1'b1;
                tx_got   = 8'h00;
            end
            if (tx_cyc >= 0) begin
                b  = tx_cyc / tx_div;
                eb = b == 0 ? 1'b0 : b == 9 ? 1'b1 : tx_exp[b-1];
                if (TXD !== eb) tx_ok = 1'b0;
                if (b >= 1 && b <= 8 && tx_cyc % tx_div == tx_div / 2) tx_got[b-1] = TXD;
                tx_cyc++;
                if (tx_cyc == 10 * tx_div) begin
                    n_cmp++;
                    if (!tx_ok || tx_unexp) begin
                        n_bad++;
                        $display("FAIL tx_frame: got byte %h (bit timing ok=%0d, unexpected=%0d), expected %h", tx_got, tx_ok, tx_unexp, tx_exp);
                    end
                    tx_cyc = -1;
                end
            end
        end
        if (rd_dp) begin
            n_cmp++;
            if (rd_q.size() == 0) begin
                n_bad++;
                $display("FAIL read: got %h with no expectation queued", HRDATA);
            end else begin
                e = rd_q.pop_front();
                if (HRDATA !== e.v) begin
                    n_bad++;
                    $display("FAIL %s: got %h, expected %h", e.nm, HRDATA, e.v);
                end
            end
        end
        while (pin_q.size() != 0) begin
            e   = pin_q.pop_front();
            act = e.sel == 0 ? {31'd0, IRQ_UART} : e.sel == 1 ? {31'd0, TXD} : tx_q.size() + (tx_cyc >= 0 ? 1 : 0);
            n_cmp++;
            if (act !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %h, expected %h", e.nm, act, e.v);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pin(input string nm, input int sel, input logic [31:0] v);
        pin_q.push_back('{nm, sel, v});
        @(negedge clk);
        #1;
    endtask

    task automatic ahb_wr(input logic [3:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = {28'd0, a};
        @(posedge clk);
        #1;
        HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HWDATA = d;
    endtask

    task automatic ahb_rd(input logic [3:0] a, input logic [31:0] v, input string nm);
        rd_q.push_back('{nm, 0, v});
        @(posedge clk);
        #1;
        HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = {28'd0, a};
        @(posedge clk);
        #1;
        HSEL = 0; HTRANS = 2'b00;
    endtask

    task automatic tx_byte(input logic [7:0] b);
        if (tx_q.size() < DEPTH) tx_q.push_back(b);
        ahb_wr(4'h0, {24'd0, b});
    endtask

    task automatic set_baud(input int v);
        ahb_wr(4'hC, v);
        m_baud = v < 4 ? 4 : v;
        ahb_rd(4'hC, m_baud, "baud_readback");
    endtask

    task automatic drain();
        int n = 0;
        while ((tx_q.size() != 0 || tx_cyc >= 0) && n < 30000) begin
            @(posedge clk);
            n++;
        end
        idle(2);
        pin("tx_drain", 2, 0);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stp);
        logic [9:0] f;
        f = {stp, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RXD = f[i];
            repeat (m_baud) @(posedge clk);
            #1;
        end
        RXD = 1'b1;
        idle(4);
        if (stp) begin
            m_ovr     = m_ovr | m_rxv;
            m_rxv     = 1'b1;
            m_rx_data = b;
        end else m_ferr = 1'b1;
    endtask

    function automatic logic [31:0] st_rx();
        return {26'd0, m_ferr, 1'b0, m_ovr, m_rxv, 1'b1, 1'b0};
    endfunction

    function automatic logic [31:0] st_tx_stalled();
        return {26'd0, 1'b0, 1'b1, 1'b0, 1'b0, tx_q.size() == 0, tx_q.size() == DEPTH};
    endfunction

    task automatic read_data(input string nm);
        ahb_rd(4'h0, {24'd0, m_rx_data}, nm);
        m_rxv = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] b, c;
        HSEL = 0; HTRANS = 0; HADDR = 0; HWRITE = 0; HWDATA = 0; HSIZE = 3'd2; HREADY = 1; RXD = 1; RSTn = 0;
        idle(3);
        RSTn = 1;
        pin("rst_txd", 1, 1);
        pin("rst_irq", 0, 0);
        ahb_rd(4'h4, 32'h02, "rst_status");
        ahb_rd(4'hC, 32'd8, "rst_baud");
        ahb_rd(4'h8, 32'd0, "rst_ctrl");

        tx_byte(8'hA5);
        ahb_rd(4'h4, 32'h12, "tx_busy_status");
        drain();
        ahb_rd(4'h4, 32'h02, "tx_idle_status");

        set_baud(2);
        set_baud($urandom_range(0, 12));
        for (int i = 0; i < 4; i++) tx_byte(8'($urandom));
        drain();

        set_baud(100);
        for (int k = 1; k <= 10; k++) begin
            tx_byte(8'(k));
            if (k == 8 || k == 9) ahb_rd(4'h4, st_tx_stalled(), k == 8 ? "fifo_not_full" : "fifo_full");
        end
        drain();
        set_baud(8);

        for (int i = 0; i < 3; i++) begin
            send_rx(8'($urandom), 1'b1);
            ahb_rd(4'h4, st_rx(), "rx_status");
            read_data("rx_data");
        end

        b = 8'h3C;
        c = 8'($urandom);
        send_rx(b, 1'b1);
        send_rx(c, 1'b1);
        ahb_rd(4'h4, st_rx(), "overrun_status");
        read_data("overrun_data");
        ahb_wr(4'h4, 32'h08);
        m_ovr = 1'b0;
        ahb_rd(4'h4, st_rx(), "overrun_cleared");

        @(posedge clk);
        #1;
        RXD = 1'b0;
        idle(2);
        RXD = 1'b1;
        idle(30);
        ahb_rd(4'h4, st_rx(), "glitch_status");

        send_rx(8'h55, 1'b0);
        ahb_rd(4'h4, st_rx(), "ferr_status");
        ahb_wr(4'h4, 32'h20);
        m_ferr = 1'b0;
        ahb_rd(4'h4, st_rx(), "ferr_cleared");

        ahb_wr(4'h8, 32'h1);
        ahb_rd(4'h8, 32'h1, "ctrl_readback");
        pin("irq_quiet", 0, 0);
        send_rx(8'h7E, 1'b1);
        pin("irq_rx", 0, 1);
        read_data("irq_data");
        idle(2);
        pin("irq_rx_clear", 0, 0);
        ahb_wr(4'h8, 32'h2);
        idle(2);
        pin("irq_tx_idle", 0, 1);

        tx_byte(8'($urandom));
        idle(30);
        RSTn = 1'b0;
        tx_q.delete();
        pin("rst_mid_txd", 1, 1);
        pin("rst_mid_irq", 0, 0);
        idle(2);
        RSTn = 1'b1;
        m_baud = 8; m_rxv = 0; m_ovr = 0; m_ferr = 0; m_rx_data = 0;
        ahb_rd(4'h4, 32'h02, "rst_mid_status");
        ahb_rd(4'hC, 32'd8, "rst_mid_baud");
        ahb_rd(4'h8, 32'd0, "rst_mid_ctrl");
        idle(200);
        pin("tx_after_reset", 2, 0);

        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
